logic_pod_ram_writer: RTL and testbench

Drains the per-pod 256-bit data FIFOs and 29-bit address FIFOs, which the logic-pod arbiters fill, into the DDR controller's native app/write-data interface in the RAM clock domain. It round-robins between pods 0 and 1, emitting one two-beat write burst per address entry. It sits on the read side of the clock-crossing FIFOs, directly downstream of the per-pod arbiters.

---
 rtl/logic_pod_ram_pkg.sv | 15 +
 rtl/logic_pod_ram_writer.sv | 88 ++++++++
 tb/tb_logic_pod_ram_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/logic_pod_ram_pkg.sv
// logic_pod_ram_pkg: shared FSM encoding and DDR write constants for the logic-pod RAM writer
package logic_pod_ram_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD0,
    S_LOAD1,
    S_WDF0,
    S_WDF1,
    S_CMD
  } state_t;
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam int ADDR_VALID_BIT = 28;
  localparam int BURST_BEATS = 2;
endpackage

// File: rtl/logic_pod_ram_writer.sv
// logic_pod_ram_writer: round-robin drain of two pod addr/data FIFOs into two-beat DDR app write bursts
module logic_pod_ram_writer
  import logic_pod_ram_pkg::*;
(
  input  logic             clk_ram,
  input  logic             rst,
  input  logic [1:0]       addr_fifo_empty,
  output logic [1:0]       addr_fifo_rd_en,
  input  logic [1:0][28:0] addr_fifo_rd_data,
  output logic [1:0]       data_fifo_rd_en,
  input  logic [1:0][255:0] data_fifo_rd_data,
  input  logic [1:0][8:0]  data_fifo_rd_size,
  output logic             app_en,
  output logic [2:0]       app_cmd,
  output logic [28:0]      app_addr,
  input  logic             app_rdy,
  output logic             app_wdf_wren,
  output logic [255:0]     app_wdf_data,
  output logic [31:0]      app_wdf_mask,
  output logic             app_wdf_end,
  input  logic             app_wdf_rdy,
  output logic             idle,
  output logic             err_bad_cmd,
  output logic [31:0]      burst_count
);
  state_t state;
  logic sel, last_pod, discard;
  logic [27:0] addr_q;
  logic [255:0] d0, d1;
  logic [1:0] elig, sel_oh;
  logic next_sel;
  assign elig[0] = !addr_fifo_empty[0] && (data_fifo_rd_size[0] >= 9'd2);
  assign elig[1] = !addr_fifo_empty[1] && (data_fifo_rd_size[1] >= 9'd2);
  // on a tie serve the pod not served last; otherwise the single eligible pod
  assign next_sel = (elig == 2'b11) ? ~last_pod : ~elig[0];
  assign sel_oh = sel ? 2'b10 : 2'b01;
  always_ff @(posedge clk_ram) begin
    if (rst) begin
      state <= S_IDLE;
      sel <= 1'b0;
      last_pod <= 1'b1;
      discard <= 1'b0;
      addr_q <= '0;
      d0 <= '0;
      d1 <= '0;
      err_bad_cmd <= 1'b0;
      burst_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (|elig) begin
          sel <= next_sel;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD0;
        S_LOAD0: begin
          addr_q <= addr_fifo_rd_data[sel][27:0];
          d0 <= data_fifo_rd_data[sel];
          discard <= !addr_fifo_rd_data[sel][ADDR_VALID_BIT];
          if (!addr_fifo_rd_data[sel][ADDR_VALID_BIT]) err_bad_cmd <= 1'b1;
          state <= S_LOAD1;
        end
        S_LOAD1: begin
          d1 <= data_fifo_rd_data[sel];
          state <= discard ? S_IDLE : S_WDF0;
        end
        S_WDF0: if (app_wdf_rdy) state <= S_WDF1;
        S_WDF1: if (app_wdf_rdy) state <= S_CMD;
        S_CMD: if (app_rdy) begin
          burst_count <= burst_count + 32'd1;
          last_pod <= sel;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // address pops once per burst, data pops twice so discarded bursts keep the FIFOs aligned
  assign addr_fifo_rd_en = (state == S_FETCH) ? sel_oh : 2'b00;
  assign data_fifo_rd_en = (state == S_FETCH || state == S_LOAD0) ? sel_oh : 2'b00;
  assign app_wdf_wren = (state == S_WDF0) || (state == S_WDF1);
  assign app_wdf_end = (state == S_WDF1);
  assign app_wdf_data = (state == S_WDF1) ? d1 : d0;
  assign app_wdf_mask = '0;
  assign app_en = (state == S_CMD);
  assign app_cmd = APP_CMD_WRITE;
  assign app_addr = {1'b0, addr_q};
  assign idle = (state == S_IDLE);
endmodule

// File: tb/tb_logic_pod_ram_writer.sv
// tb_logic_pod_ram_writer: scoreboard bench with FIFO models and a DDR app-side monitor
module tb_logic_pod_ram_writer;
  import logic_pod_ram_pkg::*;
  logic clk_ram = 1'b0;
  logic rst = 1'b1;
  always #5 clk_ram = ~clk_ram;
  logic [1:0] addr_fifo_empty = 2'b11;
  logic [1:0] addr_fifo_rd_en, data_fifo_rd_en;
  logic [1:0][28:0] addr_fifo_rd_data = '0;
  logic [1:0][255:0] data_fifo_rd_data = '0;
  logic [1:0][8:0] data_fifo_rd_size = '0;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, idle, err_bad_cmd;
  logic [2:0] app_cmd;
  logic [28:0] app_addr;
  logic [255:0] app_wdf_data;
  logic [31:0] app_wdf_mask, burst_count;
  logic_pod_ram_writer dut (
    .clk_ram(clk_ram), .rst(rst),
    .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd_en(addr_fifo_rd_en), .addr_fifo_rd_data(addr_fifo_rd_data),
    .data_fifo_rd_en(data_fifo_rd_en), .data_fifo_rd_data(data_fifo_rd_data), .data_fifo_rd_size(data_fifo_rd_size),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .idle(idle), .err_bad_cmd(err_bad_cmd), .burst_count(burst_count)
  );
  typedef struct {
    logic [28:0] a;
    logic [255:0] d0;
    logic [255:0] d1;
  } burst_t;
  burst_t exp_q[$];
  logic [28:0] aq0[$], aq1[$];
  logic [255:0] dq0[$], dq1[$];
  int tests = 0, fails = 0;
  int dpops = 0, apops = 0, cmds = 0, beats = 0, underflow = 0;
  logic [255:0] bd0, bd1;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] dw(input int x);
    return {8{32'(x)}};
  endfunction
  task automatic push(input int p, input logic [28:0] a, input logic [255:0] d0, input logic [255:0] d1, input bit expect_out);
    burst_t b;
    if (p == 0) begin
      aq0.push_back(a);
      dq0.push_back(d0);
      dq0.push_back(d1);
    end else begin
      aq1.push_back(a);
      dq1.push_back(d0);
      dq1.push_back(d1);
    end
    b.a = {1'b0, a[27:0]};
    b.d0 = d0;
    b.d1 = d1;
    if (expect_out) exp_q.push_back(b);
  endtask
  // clock-crossing FIFO read sides: data valid the cycle after rd_en, status registered
  always @(posedge clk_ram) begin
    if (rst) begin
      aq0.delete(); aq1.delete(); dq0.delete(); dq1.delete();
      addr_fifo_rd_data <= '0;
      data_fifo_rd_data <= '0;
    end else begin
      if (addr_fifo_rd_en[0]) begin apops++; if (aq0.size() > 0) addr_fifo_rd_data[0] <= aq0.pop_front(); else underflow++; end
      if (addr_fifo_rd_en[1]) begin apops++; if (aq1.size() > 0) addr_fifo_rd_data[1] <= aq1.pop_front(); else underflow++; end
      if (data_fifo_rd_en[0]) begin dpops++; if (dq0.size() > 0) data_fifo_rd_data[0] <= dq0.pop_front(); else underflow++; end
      if (data_fifo_rd_en[1]) begin dpops++; if (dq1.size() > 0) data_fifo_rd_data[1] <= dq1.pop_front(); else underflow++; end
    end
    addr_fifo_empty <= {aq1.size() == 0, aq0.size() == 0};
    data_fifo_rd_size <= {9'(dq1.size()), 9'(dq0.size())};
  end
  // app-side monitor: collect beats, compare each accepted command against the scoreboard
  always @(negedge clk_ram) begin
    if (rst) beats = 0;
    else begin
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("wdf_end", 256'(app_wdf_end), 256'(beats == 1));
        chk("wdf_mask", 256'(app_wdf_mask), 256'(0));
        if (beats == 0) bd0 = app_wdf_data;
        if (beats == 1) bd1 = app_wdf_data;
        beats++;
      end
      if (app_en && app_rdy) begin
        cmds++;
        chk("beats_before_cmd", 256'(beats), 256'(BURST_BEATS));
        chk("app_cmd", 256'(app_cmd), 256'(APP_CMD_WRITE));
        chk("cmd_expected", 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          burst_t b;
          b = exp_q.pop_front();
          chk("cmd_addr", 256'(app_addr), 256'(b.a));
          chk("beat0_data", bd0, b.d0);
          chk("beat1_data", bd1, b.d1);
        end
        beats = 0;
      end
    end
  end
  task automatic drain(input string tag, input int maxc);
    int ok = 0;
    for (int i = 0; i < maxc && ok == 0; i++) begin
      @(negedge clk_ram);
      if (idle && exp_q.size() == 0 && aq0.size() == 0 && aq1.size() == 0 && addr_fifo_empty == 2'b11) ok = 1;
    end
    chk(tag, 256'(ok), 256'(1));
  endtask
  task automatic wait_sig(input string tag, input bit want_cmd, input int maxc);
    int ok = 0;
    for (int i = 0; i < maxc && ok == 0; i++) begin
      @(negedge clk_ram);
      if (want_cmd ? app_en : app_wdf_wren) ok = 1;
    end
    chk(tag, 256'(ok), 256'(1));
  endtask
  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_idle"}, 256'(idle), 256'(1));
    chk({pfx, "_rd_en"}, 256'({addr_fifo_rd_en, data_fifo_rd_en}), 256'(0));
    chk({pfx, "_app_en"}, 256'(app_en), 256'(0));
    chk({pfx, "_wren"}, 256'(app_wdf_wren), 256'(0));
    chk({pfx, "_end"}, 256'(app_wdf_end), 256'(0));
    chk({pfx, "_addr"}, 256'(app_addr), 256'(0));
    chk({pfx, "_data"}, app_wdf_data, 256'(0));
    chk({pfx, "_err"}, 256'(err_bad_cmd), 256'(0));
    chk({pfx, "_count"}, 256'(burst_count), 256'(0));
  endtask
  initial begin
    int tn, tw, te, tc, p0, c0, busy;
    logic [28:0] cap;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (3) @(posedge clk_ram);
    @(negedge clk_ram);
    chk_reset_outputs("reset");
    @(posedge clk_ram); #1 rst = 1'b0;
    push(0, 29'h1800_0004, dw(1), dw(2), 1);
    tn = -1; tw = -1; te = -1; tc = -1; cap = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_ram);
      if (tn < 0 && idle && !addr_fifo_empty[0] && data_fifo_rd_size[0] >= 9'd2) tn = i;
      if (tw < 0 && app_wdf_wren) tw = i;
      if (te < 0 && app_wdf_end) te = i;
      if (tc < 0 && app_en) begin tc = i; cap = app_addr; end
    end
    chk("lat_first_beat", 256'(tw - tn), 256'(4));
    chk("lat_wdf_end", 256'(te - tn), 256'(5));
    chk("lat_app_en", 256'(tc - tn), 256'(6));
    chk("single_addr", 256'(cap), 256'(29'h0800_0004));
    chk("single_count", 256'(burst_count), 256'(1));
    app_wdf_rdy = 1'b0;
    p0 = dpops; c0 = cmds;
    push(1, 29'h1C00_0100, dw(3), dw(4), 1);
    wait_sig("stall_wren_seen", 1'b0, 30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ram);
      chk("stall_wren_held", 256'(app_wdf_wren), 256'(1));
      chk("stall_data_held", app_wdf_data, dw(3));
    end
    chk("stall_wdf_pops", 256'(dpops - p0), 256'(2));
    @(posedge clk_ram); #1 app_wdf_rdy = 1'b1; app_rdy = 1'b0;
    wait_sig("stall_cmd_seen", 1'b1, 10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ram);
      chk("stall_app_en_held", 256'(app_en), 256'(1));
      chk("stall_addr_held", 256'(app_addr), 256'(29'h0C00_0100));
    end
    chk("stall_cmd_pops", 256'(dpops - p0), 256'(2));
    @(posedge clk_ram); #1 app_rdy = 1'b1;
    drain("stall_drain", 30);
    chk("stall_cmds", 256'(cmds - c0), 256'(1));
    chk("stall_count", 256'(burst_count), 256'(2));
    p0 = dpops; c0 = cmds;
    push(0, 29'h0123_4560, dw(7), dw(8), 0);
    push(1, 29'h1300_0020, dw(9), dw(10), 1);
    drain("bad_drain", 60);
    chk("bad_err", 256'(err_bad_cmd), 256'(1));
    chk("bad_pops", 256'(dpops - p0), 256'(4));
    chk("bad_cmds", 256'(cmds - c0), 256'(1));
    p0 = dpops;
    begin
      burst_t b;
      b.a = 29'h0000_0080; b.d0 = dw(11); b.d1 = dw(12);
      aq0.push_back(29'h1000_0080);
      dq0.push_back(dw(11));
      exp_q.push_back(b);
    end
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ram);
      if (!idle) busy++;
    end
    chk("size1_idle", 256'(busy), 256'(0));
    chk("size1_no_pop", 256'(dpops - p0), 256'(0));
    @(posedge clk_ram); #1 dq0.push_back(dw(12));
    drain("size1_drain", 30);
    chk("size1_pops", 256'(dpops - p0), 256'(2));
    app_wdf_rdy = 1'b0;
    push(0, 29'h1000_0040, dw(5), dw(6), 0);
    wait_sig("rst_wren_seen", 1'b0, 30);
    @(posedge clk_ram); #1 app_wdf_rdy = 1'b1;
    @(posedge clk_ram); #1 app_wdf_rdy = 1'b0; rst = 1'b1;
    @(negedge clk_ram);
    chk("rst_in_wdf1", 256'(app_wdf_end), 256'(1));
    @(negedge clk_ram);
    chk_reset_outputs("midrst");
    @(posedge clk_ram); #1 rst = 1'b0; app_wdf_rdy = 1'b1;
    c0 = cmds;
    for (int j = 0; j < 3; j++) begin
      push(0, {1'b1, 1'b0, 3'(j), 22'(j + 1), 2'b00}, dw(100 + 2 * j), dw(101 + 2 * j), 1);
      push(1, {1'b1, 1'b1, 3'(j), 22'(j + 50), 2'b00}, dw(200 + 2 * j), dw(201 + 2 * j), 1);
    end
    drain("rr_drain", 200);
    chk("rr_cmds", 256'(cmds - c0), 256'(6));
    chk("rr_count", 256'(burst_count), 256'(6));
    chk("no_underflow", 256'(underflow), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
